// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared state encoding, default sizes and depth helper for reg_file_p
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;

    typedef logic [0:0] rf_state_t;
    localparam rf_state_t RF_CLEAR = 1'b0;
    localparam rf_state_t RF_RUN   = 1'b1;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_file_p_if.sv
// rtl/reg_file_p_if.sv - read/write port bundle for reg_file_p
interface reg_file_p_if import rf_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) ();

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ready;
    logic              wr_drop;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
        input  rd_data1, rd_data2, ready, wr_drop
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
        output rd_data1, rd_data2, ready, wr_drop
    );

endinterface

// File: rtl/reg_file_p_clear_ctrl.sv
// rtl/reg_file_p_clear_ctrl.sv - post-reset clear sweep FSM, ready and wr_drop generation
module rf_clear_ctrl import rf_pkg::*; #(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    output logic              ready,
    output logic              wr_drop,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int DEPTH = rf_depth(ADDR_W);

    rf_state_t         state;
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en & ~ready;
            if (state == RF_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state <= RF_RUN;
                    ready <= 1'b1;
                end
            end
        end
    end

    // The reset edge itself must never touch the array.
    assign clr_en   = (state == RF_CLEAR) & ~rst;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/reg_file_p.sv
// rtl/reg_file_p.sv - 2R1W register file with hardware clear; RF_BYPASS_EN adds write-to-read bypass
module reg_file_p import rf_pkg::*; #(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_p_if.slave  bus
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              ready;
    logic              wr_drop;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    rf_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .ready    (ready),
        .wr_drop  (wr_drop),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign wr_ok = bus.wr_en & ready & ~rst & ~((ZERO_REG != 0) && (bus.wr_addr == '0));

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd1 = mem[bus.rd_addr1];
`ifdef RF_BYPASS_EN
        if (bus.wr_en && (bus.rd_addr1 == bus.wr_addr)) rd1 = bus.wr_data;
`endif
        // Ready gating and zero-register suppression override any bypass.
        if (!ready || ((ZERO_REG != 0) && (bus.rd_addr1 == '0))) rd1 = '0;
    end

    always_comb begin
        rd2 = mem[bus.rd_addr2];
`ifdef RF_BYPASS_EN
        if (bus.wr_en && (bus.rd_addr2 == bus.wr_addr)) rd2 = bus.wr_data;
`endif
        if (!ready || ((ZERO_REG != 0) && (bus.rd_addr2 == '0))) rd2 = '0;
    end

    assign bus.rd_data1 = rd1;
    assign bus.rd_data2 = rd2;
    assign bus.ready    = ready;
    assign bus.wr_drop  = wr_drop;

endmodule

// File: tb/tb_reg_file_p.sv
// tb/tb_reg_file_p.sv - directed bench for reg_file_p (expects RF_BYPASS_EN to match the RTL build)
module tb_reg_file_p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    reg_file_p_if #(.DATA_W(16), .ADDR_W(3)) bus ();
    reg_file_p_if #(.DATA_W(16), .ADDR_W(3)) bus_nz ();

    assign bus_nz.rd_addr1 = bus.rd_addr1;
    assign bus_nz.rd_addr2 = bus.rd_addr2;
    assign bus_nz.wr_en    = bus.wr_en;
    assign bus_nz.wr_addr  = bus.wr_addr;
    assign bus_nz.wr_data  = bus.wr_data;

    reg_file_p #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    reg_file_p #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_nz (
        .clk (clk),
        .rst (rst),
        .bus (bus_nz.slave)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_bypass;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Reset held for two edges
        tick();
        tick();
        #1;
        chk("rst_ready", {15'd0, bus.ready}, 16'd0);
        chk("rst_wr_drop", {15'd0, bus.wr_drop}, 16'd0);
        chk("rst_rd1", bus.rd_data1, 16'h0000);
        chk("rst_rd2", bus.rd_data2, 16'h0000);

        // Clear sweep, with a write attempt to reg 5 on the first sweep edge
        rst = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd5;
        bus.wr_data = 16'h00FF;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 1) begin
                chk("drop_pulse", {15'd0, bus.wr_drop}, 16'd1);
                bus.wr_en = 1'b0;
            end
            if (e == 2) chk("drop_clears", {15'd0, bus.wr_drop}, 16'd0);
            chk($sformatf("sweep_ready_e%0d", e), {15'd0, bus.ready}, 16'd0);
            bus.rd_addr1 = 3'd5;
            #1;
            chk($sformatf("sweep_rd1_e%0d", e), bus.rd_data1, 16'h0000);
        end
        tick();
        chk("ready_e8", {15'd0, bus.ready}, 16'd1);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr1 = 3'(a);
            bus.rd_addr2 = 3'(7 - a);
            #1;
            chk($sformatf("clr_rd1_r%0d", a), bus.rd_data1, 16'h0000);
            chk($sformatf("clr_rd2_r%0d", 7 - a), bus.rd_data2, 16'h0000);
        end

        // Same-cycle write and read of reg 3
`ifdef RF_BYPASS_EN
        exp_bypass = 16'hBEEF;
`else
        exp_bypass = 16'h0000;
`endif
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd3;
        bus.wr_data  = 16'hBEEF;
        bus.rd_addr1 = 3'd3;
        #1;
        chk("same_cycle_rd1", bus.rd_data1, exp_bypass);
        tick();
        bus.wr_en    = 1'b0;
        bus.rd_addr2 = 3'd3;
        #1;
        chk("after_wr_rd1", bus.rd_data1, 16'hBEEF);
        chk("after_wr_rd2", bus.rd_data2, 16'hBEEF);

        // Write to reg 0: suppressed with ZERO_REG=1, stored with ZERO_REG=0
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 16'h1234;
        tick();
        bus.wr_en    = 1'b0;
        bus.rd_addr1 = 3'd0;
        bus.rd_addr2 = 3'd0;
        #1;
        chk("zero_reg_rd1", bus.rd_data1, 16'h0000);
        chk("zero_reg_rd2", bus.rd_data2, 16'h0000);
        chk("zero_reg_no_drop", {15'd0, bus.wr_drop}, 16'd0);
        chk("nz_reg0_rd1", bus_nz.rd_data1, 16'h1234);

        // Dropped sweep write never reached reg 5
        bus.rd_addr1 = 3'd5;
        #1;
        chk("reg5_after_drop", bus.rd_data1, 16'h0000);

        // Fill regs 1..7, then reset mid-run
        for (int i = 1; i < 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'(i);
            bus.wr_data = 16'(16'h0011 * i);
            tick();
        end
        bus.wr_en    = 1'b0;
        bus.rd_addr1 = 3'd7;
        bus.rd_addr2 = 3'd4;
        #1;
        chk("fill_r7", bus.rd_data1, 16'h0077);
        chk("fill_r4", bus.rd_data2, 16'h0044);
        rst = 1'b1;
        tick();
        chk("midrst_ready", {15'd0, bus.ready}, 16'd0);
        chk("midrst_rd1", bus.rd_data1, 16'h0000);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        chk("resweep_ready_e7", {15'd0, bus.ready}, 16'd0);
        tick();
        chk("resweep_ready_e8", {15'd0, bus.ready}, 16'd1);
        for (int a = 1; a < 8; a++) begin
            bus.rd_addr1 = 3'(a);
            #1;
            chk($sformatf("resweep_rd_r%0d", a), bus.rd_data1, 16'h0000);
        end

        // Back-to-back writes 1:A, 2:B, 1:C
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd1;
        bus.wr_data = 16'h000A;
        tick();
        bus.wr_addr = 3'd2;
        bus.wr_data = 16'h000B;
        tick();
        bus.wr_addr = 3'd1;
        bus.wr_data = 16'h000C;
        tick();
        bus.wr_en    = 1'b0;
        bus.rd_addr1 = 3'd1;
        bus.rd_addr2 = 3'd2;
        #1;
        chk("b2b_rd1", bus.rd_data1, 16'h000C);
        chk("b2b_rd2", bus.rd_data2, 16'h000B);
        bus.rd_addr1 = 3'd2;
        bus.rd_addr2 = 3'd1;
        #1;
        chk("b2b_swap_rd1", bus.rd_data1, 16'h000B);
        chk("b2b_swap_rd2", bus.rd_data2, 16'h000C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish by 50000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_p.md
Name: reg_file_p

Overview:
Parametrised successor to the MIPS multi-cycle register file. It provides DEPTH x DATA_W storage, two asynchronous read ports and one synchronous write port. A hardware clear sequencer zeroes every entry after reset and reports readiness. Optional write-to-read bypass is available. It sits in the datapath between instruction decode and the ALU/writeback mux.

Parameters:
DATA_W, 16, width of each register and of the data ports.
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
ZERO_REG, 1, when 1, entry 0 reads as 0 and writes to it are discarded.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
rd_addr1  in  ADDR_W  read port 1 address.
rd_addr2  in  ADDR_W  read port 2 address.
rd_data1  out  DATA_W  read port 1 data (combinational).
rd_data2  out  DATA_W  read port 2 data (combinational).
wr_en  in  1  write request.
wr_addr  in  ADDR_W  write address.
wr_data  in  DATA_W  write data.
ready  out  1  high once the clear sweep has finished; accesses are valid.
wr_drop  out  1  registered one-cycle pulse: a write request was discarded because ready was low.

Behaviour:
- Reset behaviour is decided: one clock, clk; reset rst is synchronous and active-high.
- FSM states: CLEAR and RUN.
  - rst high at an edge: state <= CLEAR, clr_ptr <= 0, ready <= 0, wr_drop <= 0. Memory is not written on that edge.
  - CLEAR, rst low: mem[clr_ptr] <= 0 each edge, clr_ptr <= clr_ptr+1. On the edge where clr_ptr == DEPTH-1, state <= RUN and ready <= 1.
  - Clear latency: ready rises on the DEPTH-th rising edge after the first edge with rst low (8 edges at the defaults).
  - RUN stays in RUN until rst. rst asserted mid-operation restarts the sweep from 0, and ready drops on that edge.
- Initial contents before the first reset are undefined; the design and bench must apply rst before use.
- Write: in RUN with wr_en high, mem[wr_addr] <= wr_data on the edge. If ZERO_REG=1 and wr_addr == 0, the write is discarded silently (no wr_drop).
- wr_drop <= wr_en & ~ready & ~rst, so it is registered and visible one cycle later. In CLEAR, user writes never reach memory.
- Read: rd_dataN = 0 while ready low. Otherwise rd_dataN = 0 if ZERO_REG=1 and rd_addrN == 0; else mem[rd_addrN]. The read is purely combinational and the outputs update in the same cycle as the address.
- Reset values: ready=0, wr_drop=0, rd_data1=rd_data2=0 (forced by ready low).
- Same-address read and write in the same cycle: without bypass, the read returns the old value and the new value appears after the edge.
- Both read ports may address the same entry; each returns the identical value.
- clr_ptr wraps naturally at DEPTH-1, but the FSM leaves CLEAR at that point, so no second sweep occurs.

Optional Feature:
- Macro RF_BYPASS_EN.
  - When defined: if ready, wr_en, rd_addrN == wr_addr, and the address is not a suppressed zero register, rd_dataN = wr_data combinationally in the same cycle. This gives write-first semantics, used by the pipelined successor to remove a forwarding stage.
  - When undefined: read-first semantics as described above. No bypass muxes are present.

Decomposition:
- Package rf_pkg holds:
  - state typedef/localparams RF_CLEAR=1'b0 and RF_RUN=1'b1;
  - default DATA_W/ADDR_W constants;
  - function rf_depth(addr_w) returning 2**addr_w.
- One natural sub-module, rf_clear_ctrl. It contains the FSM, clr_ptr, ready and wr_drop generation, and outputs the clear-write enable/address to the storage array.
- Storage and read/bypass muxing stay in reg_file_p.

Test Plan:
1. rst high 2 cycles, then low -> ready=0 and rd_data1/2=0 for 7 edges; ready=1 after the 8th edge; all 8 entries read 0.
2. After ready: write 16'hBEEF to reg 3, read rd_addr1=3 same cycle -> old 0 without RF_BYPASS_EN (16'hBEEF with it); next cycle 16'hBEEF on both ports with rd_addr2=3.
3. Write 16'h1234 to reg 0 with ZERO_REG=1 -> reads of reg 0 stay 0 and wr_drop stays 0; rebuild with ZERO_REG=0 -> reg 0 reads 16'h1234.
4. wr_en=1, addr 5, data 16'h00FF during the clear sweep -> wr_drop=1 the following cycle and reg 5 reads 0 after ready.
5. Fill regs 1..7 with 16'h0011*i, then pulse rst for 1 cycle mid-run -> ready drops on that edge, sweep restarts, and all regs read 0 after 8 further edges.
6. Back-to-back writes to regs 1, 2, 1 with 16'hA, 16'hB, 16'hC on consecutive cycles -> reg1=16'hC and reg2=16'hB; port 1 and port 2 reading regs 1 and 2 simultaneously return those values.
